sdram2disp: RTL and testbench
=============================

SDRAM2DISP -- requirements
Module: sdram2disp

Interface
REQ-001 Parameter DEPTH, default 1024; line-buffer depth in 16-bit words, power of two.
REQ-002 Parameter BURST_LEN, default 256; words per SDRAM read burst, must not exceed DEPTH.
REQ-003 Parameter FRAME_WORDS, default 307200; words per frame (640x480).
REQ-004 Parameter AW, default 22; SDRAM word-address width.
REQ-005 clk_133M_i  in  1  single clock, SDRAM controller domain.
REQ-006 rst_133i  in  1  reset, asynchronous, active-low.
REQ-007 vsyn_pos  in  1  one-cycle frame-start pulse, synchronous to clk_133M_i.
REQ-008 work_st  in  5  SDRAM controller state; value 6 (W_RDDAT) marks a valid read-data word.
REQ-009 rd_sdram_data  in  16  SDRAM read data.
REQ-010 rd_req_o  out  1  burst read request to the SDRAM controller.
REQ-011 rd_ack_i  in  1  one-cycle pulse: controller accepted rd_req_o.
REQ-012 rd_addr_o  out  AW  start word address of the requested burst.
REQ-013 pix_data_o  out  16  pixel word to the display side.
REQ-014 pix_valid_o  out  1  pix_data_o holds a valid word.
REQ-015 pix_ready_i  in  1  display side consumes the word when pix_valid_o is high.
REQ-016 fifo_used_o  out  $clog2(DEPTH)+1  current buffer fill level.
REQ-017 underflow_o  out  1  sticky underflow flag (see Configuration).

Function
REQ-018 FSM states: R_IDLE, R_REQ, R_DATA, R_DRAIN, R_DONE.
REQ-019 R_IDLE -> R_REQ when (DEPTH - fifo_used_o) >= BURST_LEN and frame word count < FRAME_WORDS.
REQ-020 R_IDLE -> R_DONE when frame word count == FRAME_WORDS; R_DONE is left only on vsyn_pos.
REQ-021 rd_req_o is high in R_REQ only; rd_ack_i in R_REQ -> R_DATA, burst counter cleared.
REQ-022 In R_DATA, each cycle with work_st == 6 writes rd_sdram_data into the buffer and increments the burst counter; at BURST_LEN words -> R_IDLE, rd_addr_o += BURST_LEN, frame word count += BURST_LEN.
REQ-023 work_st == 6 outside R_DATA/R_DRAIN is ignored (no write).
REQ-024 Buffer is first-word-fall-through: pix_valid_o = buffer not empty; pix_data_o = oldest word; a word written into an empty buffer at cycle N is valid at cycle N+1.
REQ-025 A word is popped on a cycle where pix_valid_o && pix_ready_i.
REQ-026 Simultaneous write and pop leaves fifo_used_o unchanged; pointers wrap modulo DEPTH.
REQ-027 A write while full is dropped; fifo_used_o saturates at DEPTH. REQ-019 guarantees this is unreachable in legal operation.
REQ-028 vsyn_pos flushes the buffer (pointers and fifo_used_o = 0) and clears rd_addr_o and the frame word count; it takes priority over a same-cycle write or pop.
REQ-029 vsyn_pos in R_DATA -> R_DRAIN, which discards the remaining burst words without writing, then -> R_IDLE; vsyn_pos in any other state -> R_IDLE.
REQ-030 vsyn_pos in R_REQ with a same-cycle rd_ack_i -> R_DRAIN with the burst counter at 0.

Reset
REQ-031 rst_133i low asynchronously forces state R_IDLE, rd_req_o = 0, rd_addr_o = 0, pix_valid_o = 0, pix_data_o = 0, fifo_used_o = 0, underflow_o = 0, all counters = 0.
REQ-032 Buffer memory contents are not reset; the deassertion edge is synchronised to clk_133M_i.

Configuration
REQ-033 Macro SDRAM2DISP_UFLOW_EN defined: underflow_o is set when pix_ready_i is high, the buffer is empty, and frame word count > 0; it is cleared only by vsyn_pos or reset.
REQ-034 Macro SDRAM2DISP_UFLOW_EN undefined: underflow_o is tied to 0 and no detection logic is built.

Structure
REQ-035 A shared package holds the work_st encodings (W_IDLE..W_TRP, 0..10) and the R_* state encodings.
REQ-036 The buffer is one sub-module, disp_sfifo: a single-clock FWFT FIFO with a synchronous flush input.

Verification
REQ-037 Reset, then fifo_used_o = 0 -> rd_req_o rises in R_REQ with rd_addr_o = 0; after rd_ack_i and 256 W_RDDAT words, fifo_used_o = 256 and rd_addr_o = 256.
REQ-038 pix_ready_i held low -> exactly 4 bursts complete (fifo_used_o = 1024); rd_req_o stays low until at least 256 words are popped.
REQ-039 Continuous pix_ready_i over a full frame -> exactly 1200 bursts, then R_DONE; popped data equals the injected sequence with no loss.
REQ-040 vsyn_pos after 100 words of a burst -> fifo_used_o = 0 next cycle; the following 156 W_RDDAT words are discarded; the next request uses rd_addr_o = 0.
REQ-041 Simultaneous write and pop at fifo_used_o = 1 -> fifo_used_o stays 1 and pix_data_o advances in order.
REQ-042 With SDRAM2DISP_UFLOW_EN defined, pix_ready_i high on an empty buffer mid-frame -> underflow_o = 1 until vsyn_pos; undefined -> underflow_o stays 0.

Source files
------------

// File: rtl/sdram2disp_pkg.sv
// rtl/sdram2disp_pkg.sv - shared SDRAM controller and read-FSM state encodings
package sdram2disp_pkg;

  // SDRAM controller state as seen on work_st; W_RDDAT marks a read-data word
  typedef enum logic [4:0] {
    W_IDLE   = 5'd0,
    W_ACTIVE = 5'd1,
    W_TRCD   = 5'd2,
    W_READ   = 5'd3,
    W_CL     = 5'd4,
    W_RD     = 5'd5,
    W_RDDAT  = 5'd6,
    W_WRITE  = 5'd7,
    W_WD     = 5'd8,
    W_TWR    = 5'd9,
    W_TRP    = 5'd10
  } work_st_e;

  // Burst-read sequencer states
  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_REQ   = 3'd1,
    R_DATA  = 3'd2,
    R_DRAIN = 3'd3,
    R_DONE  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/disp_sfifo.sv
// rtl/disp_sfifo.sv - single-clock first-word-fall-through line buffer with synchronous flush
module disp_sfifo #(
  parameter int DEPTH = 1024,
  parameter int DW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   used_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [UW-1:0] used_q;
  logic          full, empty, wr_ok, rd_ok;

  assign full  = (used_q == UW'(DEPTH));
  assign empty = (used_q == '0);
  assign wr_ok = wr_en_i && !full;
  assign rd_ok = rd_en_i && !empty;

  // Storage is deliberately not reset; output is masked while empty instead
  always_ff @(posedge clk_i) begin
    if (wr_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH; flush overrides any same-cycle push or pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  assign valid_o   = !empty;
  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign used_o    = used_q;

endmodule

// File: rtl/sdram2disp.sv
// rtl/sdram2disp.sv - SDRAM burst reader feeding a display line buffer (option: SDRAM2DISP_UFLOW_EN)
module sdram2disp
  import sdram2disp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int AW          = 22
) (
  input  logic                   clk_133M_i,
  input  logic                   rst_133i,
  input  logic                   vsyn_pos,
  input  logic [4:0]             work_st,
  input  logic [15:0]            rd_sdram_data,
  output logic                   rd_req_o,
  input  logic                   rd_ack_i,
  output logic [AW-1:0]          rd_addr_o,
  output logic [15:0]            pix_data_o,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic [$clog2(DEPTH):0] fifo_used_o,
  output logic                   underflow_o
);

  localparam int UW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int FW = $clog2(FRAME_WORDS + 1);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  rd_state_e     state_q;
  logic          rd_req_q;
  logic [AW-1:0] rd_addr_q;
  logic [BW-1:0] burst_cnt_q;
  logic [FW-1:0] frame_cnt_q;
  logic [UW-1:0] free_w;
  logic          is_rddat, burst_last, fifo_wr, fifo_pop;

  // Reset asserts immediately, releases two clocks after rst_133i rises
  always_ff @(posedge clk_133M_i or negedge rst_133i) begin
    if (!rst_133i) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign is_rddat   = (work_st == W_RDDAT);
  assign burst_last = (burst_cnt_q == BW'(BURST_LEN - 1));
  assign free_w     = UW'(DEPTH) - fifo_used_o;
  assign fifo_wr    = (state_q == R_DATA) && is_rddat;
  assign fifo_pop   = pix_valid_o && pix_ready_i;

  // Burst sequencer: request, collect BURST_LEN words, or discard them after a frame restart
  always_ff @(posedge clk_133M_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= R_IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      burst_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else if (vsyn_pos) begin
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      frame_cnt_q <= '0;
      case (state_q)
        R_DATA: begin
          if (is_rddat && burst_last) begin
            state_q     <= R_IDLE;
            burst_cnt_q <= '0;
          end else begin
            state_q     <= R_DRAIN;
            burst_cnt_q <= burst_cnt_q + BW'(is_rddat);
          end
        end
        R_REQ: begin
          state_q     <= rd_ack_i ? R_DRAIN : R_IDLE;
          burst_cnt_q <= '0;
        end
        default: state_q <= R_IDLE;
      endcase
    end else begin
      case (state_q)
        R_IDLE: begin
          if (frame_cnt_q >= FW'(FRAME_WORDS)) begin
            state_q <= R_DONE;
          end else if (free_w >= UW'(BURST_LEN)) begin
            state_q  <= R_REQ;
            rd_req_q <= 1'b1;
          end
        end
        R_REQ: begin
          if (rd_ack_i) begin
            state_q     <= R_DATA;
            rd_req_q    <= 1'b0;
            burst_cnt_q <= '0;
          end
        end
        R_DATA: begin
          if (is_rddat) begin
            if (burst_last) begin
              state_q     <= R_IDLE;
              burst_cnt_q <= '0;
              rd_addr_q   <= rd_addr_q + AW'(BURST_LEN);
              frame_cnt_q <= frame_cnt_q + FW'(BURST_LEN);
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end
        end
        R_DRAIN: begin
          if (is_rddat) begin
            if (burst_last) begin
              state_q     <= R_IDLE;
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end
        end
        R_DONE:  state_q <= R_DONE;
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = rd_addr_q;

`ifdef SDRAM2DISP_UFLOW_EN
  logic underflow_q;

  // Sticky: display asked for a pixel mid-frame while the buffer was empty
  always_ff @(posedge clk_133M_i or negedge rst_n) begin
    if (!rst_n)                                                underflow_q <= 1'b0;
    else if (vsyn_pos)                                         underflow_q <= 1'b0;
    else if (pix_ready_i && !pix_valid_o && frame_cnt_q != '0) underflow_q <= 1'b1;
  end
  assign underflow_o = underflow_q;
`else
  assign underflow_o = 1'b0;
`endif

  disp_sfifo #(
    .DEPTH (DEPTH),
    .DW    (16)
  ) u_fifo (
    .clk_i     (clk_133M_i),
    .rst_ni    (rst_n),
    .flush_i   (vsyn_pos),
    .wr_en_i   (fifo_wr),
    .wr_data_i (rd_sdram_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (pix_data_o),
    .valid_o   (pix_valid_o),
    .used_o    (fifo_used_o)
  );

endmodule

// File: tb/tb_sdram2disp.sv
// tb/tb_sdram2disp.sv - scoreboard bench for sdram2disp
module tb_sdram2disp;
  import sdram2disp_pkg::*;

  localparam int DEPTH = 1024;
  localparam int BL    = 256;
  localparam int FRAME = 2048;
  localparam int AW    = 22;
`ifdef SDRAM2DISP_UFLOW_EN
  localparam bit UF_EXP = 1'b1;
`else
  localparam bit UF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_133i;
  logic          vsyn_pos;
  logic [4:0]    work_st;
  logic [15:0]   rd_sdram_data;
  logic          rd_req_o;
  logic          rd_ack_i;
  logic [AW-1:0] rd_addr_o;
  logic [15:0]   pix_data_o;
  logic          pix_valid_o;
  logic          pix_ready_i;
  logic [10:0]   fifo_used_o;
  logic          underflow_o;

  logic [15:0] exp_q [$];
  logic [15:0] seq = 16'h1000;
  logic [15:0] last_word;
  int passed = 0;
  int total  = 0;
  bit seen;

  always #5 clk = ~clk;

  sdram2disp #(
    .DEPTH(DEPTH), .BURST_LEN(BL), .FRAME_WORDS(FRAME), .AW(AW)
  ) dut (
    .clk_133M_i    (clk),
    .rst_133i      (rst_133i),
    .vsyn_pos      (vsyn_pos),
    .work_st       (work_st),
    .rd_sdram_data (rd_sdram_data),
    .rd_req_o      (rd_req_o),
    .rd_ack_i      (rd_ack_i),
    .rd_addr_o     (rd_addr_o),
    .pix_data_o    (pix_data_o),
    .pix_valid_o   (pix_valid_o),
    .pix_ready_i   (pix_ready_i),
    .fifo_used_o   (fifo_used_o),
    .underflow_o   (underflow_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Monitor: every consumed pixel must match the oldest injected word still expected
  always @(negedge clk) begin
    if (rst_133i && pix_valid_o && pix_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_unexpected: actual %0h required no pop", pix_data_o);
      end else begin
        chk("pop_data", pix_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!rd_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, rd_req_o, 1);
  endtask

  task automatic do_ack(input bit stray);
    if (stray) begin
      @(posedge clk); #1;
      work_st = W_RDDAT;
      rd_sdram_data = 16'hDEAD;
      @(posedge clk); #1;
      work_st = W_IDLE;
    end
    @(posedge clk); #1;
    rd_ack_i = 1'b1;
    @(posedge clk); #1;
    rd_ack_i = 1'b0;
  endtask

  task automatic send_words(input int n, input bit store, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 64) == 63) begin
        @(posedge clk); #1;
        work_st = W_CL;
      end
      @(posedge clk); #1;
      work_st = W_RDDAT;
      rd_sdram_data = seq;
      if (store) exp_q.push_back(seq);
      last_word = seq;
      seq++;
    end
    @(posedge clk); #1;
    work_st = W_IDLE;
  endtask

  task automatic pulse_vsyn();
    @(posedge clk); #1;
    vsyn_pos = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    vsyn_pos = 1'b0;
  endtask

  initial begin
    rst_133i = 1'b0; vsyn_pos = 1'b0; work_st = W_IDLE; rd_sdram_data = '0;
    rd_ack_i = 1'b0; pix_ready_i = 1'b0; last_word = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_req", rd_req_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_pix_data", pix_data_o, 0);
    chk("rst_used", fifo_used_o, 0);
    chk("rst_underflow", underflow_o, 0);
    @(posedge clk); #1;
    rst_133i = 1'b1;

    // First burst, with a stray data word in R_REQ and wait states inside the burst
    wait_req(20, "req_after_reset");
    chk("req1_addr", rd_addr_o, 0);
    do_ack(1'b1);
    chk("req_drop_after_ack", rd_req_o, 0);
    send_words(BL, 1'b1, 1'b1);
    @(negedge clk);
    chk("burst1_used", fifo_used_o, 256);
    chk("burst1_addr", rd_addr_o, 256);
    chk("burst1_head", pix_data_o, 16'h1000);
    chk("burst1_valid", pix_valid_o, 1);

    // Fill the buffer with no consumer: exactly four bursts fit
    for (int b = 2; b <= 4; b++) begin
      wait_req(20, "req_fill");
      chk("req_fill_addr", rd_addr_o, (b - 1) * BL);
      do_ack(1'b0);
      send_words(BL, 1'b1, 1'b0);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rd_req_o) seen = 1'b1;
    end
    chk("full_used", fifo_used_o, 1024);
    chk("full_no_req", seen, 0);

    // 255 pops are not enough room for another burst; the 256th is
    @(posedge clk); #1; pix_ready_i = 1'b1;
    repeat (255) @(posedge clk);
    #1; pix_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pop255_used", fifo_used_o, 769);
    chk("pop255_no_req", rd_req_o, 0);
    @(posedge clk); #1; pix_ready_i = 1'b1;
    @(posedge clk); #1; pix_ready_i = 1'b0;
    wait_req(10, "req_after_256_pops");
    chk("req5_addr", rd_addr_o, 1024);

    // Continuous consumption to the end of the frame
    pix_ready_i = 1'b1;
    do_ack(1'b0);
    send_words(BL, 1'b1, 1'b0);
    for (int b = 6; b <= 8; b++) begin
      wait_req(600, "req_stream");
      chk("req_stream_addr", rd_addr_o, (b - 1) * BL);
      do_ack(1'b0);
      send_words(BL, 1'b1, 1'b0);
    end
    seen = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      if (rd_req_o) seen = 1'b1;
    end
    chk("done_no_req", seen, 0);
    chk("done_used", fifo_used_o, 0);
    chk("done_scoreboard_empty", exp_q.size(), 0);
    chk("done_addr", rd_addr_o, 2048);
    chk("done_underflow", underflow_o, UF_EXP);

    // Frame restart from R_DONE, then restart in the middle of a burst
    pix_ready_i = 1'b0;
    pulse_vsyn();
    @(negedge clk);
    chk("vsyn_addr", rd_addr_o, 0);
    chk("vsyn_underflow_clr", underflow_o, 0);
    wait_req(20, "req_new_frame");
    chk("req_new_frame_addr", rd_addr_o, 0);
    do_ack(1'b0);
    send_words(100, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_burst_used", fifo_used_o, 100);
    pulse_vsyn();
    @(negedge clk);
    chk("flush_used", fifo_used_o, 0);
    chk("flush_valid", pix_valid_o, 0);
    send_words(156, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_used", fifo_used_o, 0);
    chk("drain_no_req", rd_req_o, 0);
    wait_req(20, "req_after_drain");
    chk("req_after_drain_addr", rd_addr_o, 0);

    // Simultaneous write and pop at fill level 1
    do_ack(1'b0);
    @(posedge clk); #1;
    work_st = W_RDDAT; rd_sdram_data = seq; exp_q.push_back(seq); seq++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      pix_ready_i = 1'b1;
      rd_sdram_data = seq; exp_q.push_back(seq); last_word = seq; seq++;
      @(negedge clk);
      chk("wr_pop_used", fifo_used_o, 1);
    end
    @(posedge clk); #1;
    pix_ready_i = 1'b0; work_st = W_IDLE;
    @(negedge clk);
    chk("wr_pop_used_end", fifo_used_o, 1);
    chk("wr_pop_head", pix_data_o, last_word);
    send_words(BL - 4, 1'b1, 1'b0);
    @(negedge clk);
    chk("last_burst_used", fifo_used_o, 253);
    chk("last_burst_addr", rd_addr_o, 256);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
